// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction scheduler.
//   - byte-engine command opcodes (cmd_op encodings)
//   - scheduler state enumeration
//   - default response timeout in clock cycles
package i2c_pkg;

   localparam logic [2:0] OP_START  = 3'd0;
   localparam logic [2:0] OP_RSTART = 3'd1;
   localparam logic [2:0] OP_WRITE  = 3'd2;
   localparam logic [2:0] OP_READ   = 3'd3;
   localparam logic [2:0] OP_STOP   = 3'd4;

   localparam logic [15:0] TIMEOUT_DEFAULT = 16'd4000;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_DEVW,
      ST_SUB,
      ST_WDATA,
      ST_RSTART,
      ST_DEVR,
      ST_READ,
      ST_STOP,
      ST_FIN
   } state_t;

endpackage

// File: rtl/i2c_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, reset : clock and synchronous active-high reset
//   req        : request vector from the two requesters
//   accept     : scheduler takes the offered grant this cycle
//   gnt_valid  : at least one requester is asking
//   gnt_idx    : index of the requester offered the grant
// When both ask, the one not granted last wins. Last grant resets to 1 so
// requester 0 is served first after reset.
module i2c_rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   logic last_grant;

   always_comb begin
      gnt_valid = |req;
      if (req == 2'b11)
         gnt_idx = ~last_grant;
      else
         gnt_idx = req[1];
   end

   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= 1'b1;
      else if (accept && gnt_valid)
         last_grant <= gnt_idx;
   end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// I2C register-transaction scheduler. Arbitrates two requesters and turns a
// granted register write or read into a sequence of byte-engine commands.
//   clk, reset        : clock, synchronous active-high reset
//   req/req_*         : per-requester request level and transaction fields
//   done, err, rdata  : completion pulse, error flag and read data
//   cmd_*             : command channel to the byte engine (valid/ready)
//   rsp_*             : response from the byte engine for the accepted command
//   eng_abort         : one-cycle pulse telling the engine to release the bus
module i2c_txn_scheduler
   import i2c_pkg::*;
#(
   parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [1:0]  req_rw,
   input  logic [13:0] req_dev,
   input  logic [15:0] req_sub,
   input  logic [15:0] req_wdata,
   input  logic [3:0]  req_len,
   output logic [1:0]  done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [2:0]  cmd_op,
   output logic [7:0]  cmd_data,
   output logic        cmd_mack,
   input  logic        rsp_valid,
   input  logic [7:0]  rsp_data,
   input  logic        rsp_nack,
   output logic        eng_abort
);

   state_t      state;
   logic        wait_rsp;   // command accepted, waiting for its response
   logic [15:0] tmo_cnt;
   logic        gnt;
   logic        rw;
   logic [6:0]  dev;
   logic [7:0]  sub;
   logic [7:0]  wdata;
   logic [1:0]  len;
   logic [1:0]  rd_cnt;
   logic        gnt_valid;
   logic        gnt_idx;

   i2c_rr_arb2 u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .accept    (state == ST_IDLE),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // Command fields are a pure decode of registered state and latched
   // request fields, so they stay stable while cmd_valid is held.
   always_comb begin
      cmd_op   = OP_START;
      cmd_data = 8'h00;
      cmd_mack = 1'b0;
      case (state)
         ST_DEVW:   begin cmd_op = OP_WRITE; cmd_data = {dev, 1'b0}; end
         ST_SUB:    begin cmd_op = OP_WRITE; cmd_data = sub;         end
         ST_WDATA:  begin cmd_op = OP_WRITE; cmd_data = wdata;       end
         ST_RSTART: cmd_op = OP_RSTART;
         ST_DEVR:   begin cmd_op = OP_WRITE; cmd_data = {dev, 1'b1}; end
         ST_READ:   begin cmd_op = OP_READ;  cmd_mack = (rd_cnt == len); end
         ST_STOP:   cmd_op = OP_STOP;
         default:   cmd_op = OP_START;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         wait_rsp  <= 1'b0;
         tmo_cnt   <= 16'd0;
         cmd_valid <= 1'b0;
         done      <= 2'b00;
         err       <= 1'b0;
         rdata     <= 32'd0;
         eng_abort <= 1'b0;
         gnt       <= 1'b0;
         rw        <= 1'b0;
         dev       <= 7'd0;
         sub       <= 8'd0;
         wdata     <= 8'd0;
         len       <= 2'd0;
         rd_cnt    <= 2'd0;
      end else begin
         done      <= 2'b00;
         eng_abort <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (gnt_valid) begin
                  gnt       <= gnt_idx;
                  rw        <= req_rw[gnt_idx];
                  dev       <= gnt_idx ? req_dev[13:7]   : req_dev[6:0];
                  sub       <= gnt_idx ? req_sub[15:8]   : req_sub[7:0];
                  wdata     <= gnt_idx ? req_wdata[15:8] : req_wdata[7:0];
                  len       <= gnt_idx ? req_len[3:2]    : req_len[1:0];
                  err       <= 1'b0;
                  rdata     <= 32'd0;
                  wait_rsp  <= 1'b0;
                  cmd_valid <= 1'b1;
                  state     <= ST_START;
               end
            end
            ST_FIN: state <= ST_IDLE;
            default: begin
               if (!wait_rsp) begin
                  if (cmd_valid && cmd_ready) begin
                     cmd_valid <= 1'b0;
                     wait_rsp  <= 1'b1;
                     tmo_cnt   <= 16'd0;
                  end
               end else if (rsp_valid) begin
                  wait_rsp  <= 1'b0;
                  cmd_valid <= 1'b1;
                  case (state)
                     ST_START: state <= ST_DEVW;
                     ST_DEVW: begin
                        if (rsp_nack) begin err <= 1'b1; state <= ST_STOP; end
                        else state <= ST_SUB;
                     end
                     ST_SUB: begin
                        if (rsp_nack) begin err <= 1'b1; state <= ST_STOP; end
                        else state <= rw ? ST_RSTART : ST_WDATA;
                     end
                     ST_WDATA: begin
                        if (rsp_nack) err <= 1'b1;
                        state <= ST_STOP;
                     end
                     ST_RSTART: state <= ST_DEVR;
                     ST_DEVR: begin
                        if (rsp_nack) begin err <= 1'b1; state <= ST_STOP; end
                        else begin rd_cnt <= 2'd0; state <= ST_READ; end
                     end
                     ST_READ: begin
                        rdata <= {rdata[23:0], rsp_data};
                        if (rd_cnt == len) state <= ST_STOP;
                        else rd_cnt <= rd_cnt + 2'd1;
                     end
                     default: begin   // STOP completed
                        cmd_valid <= 1'b0;
                        done      <= gnt ? 2'b10 : 2'b01;
                        state     <= ST_FIN;
                     end
                  endcase
               end else if (tmo_cnt == TIMEOUT - 16'd1) begin
                  // Engine is stuck: release the bus and finish without STOP.
                  wait_rsp  <= 1'b0;
                  eng_abort <= 1'b1;
                  err       <= 1'b1;
                  done      <= gnt ? 2'b10 : 2'b01;
                  state     <= ST_FIN;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Self-checking bench for i2c_txn_scheduler: table of transactions plus
// hand-written sequences for arbitration, timeout and mid-transaction reset.
module tb_i2c_txn_scheduler;
   import i2c_pkg::*;

   localparam logic [15:0] TMO = 16'd20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [1:0]  req_rw = 2'b00;
   logic [13:0] req_dev = 14'd0;
   logic [15:0] req_sub = 16'd0;
   logic [15:0] req_wdata = 16'd0;
   logic [3:0]  req_len = 4'd0;
   logic [1:0]  done;
   logic        err;
   logic [31:0] rdata;
   logic        cmd_valid;
   logic        cmd_ready = 1'b1;
   logic [2:0]  cmd_op;
   logic [7:0]  cmd_data;
   logic        cmd_mack;
   logic        rsp_valid = 1'b0;
   logic [7:0]  rsp_data = 8'h00;
   logic        rsp_nack = 1'b0;
   logic        eng_abort;

   i2c_txn_scheduler #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_dev(req_dev),
      .req_sub(req_sub), .req_wdata(req_wdata), .req_len(req_len),
      .done(done), .err(err), .rdata(rdata), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .cmd_mack(cmd_mack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_nack(rsp_nack), .eng_abort(eng_abort)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op; logic [7:0] data; logic mack;
      logic nack; logic [7:0] rbyte; logic silent;
   } cmd_t;
   typedef struct { logic [1:0] done; logic err; logic [31:0] rdata; } fin_t;
   typedef struct {
      logic idx; logic rw; logic [6:0] dev; logic [7:0] sub; logic [7:0] wdata;
      logic [1:0] len; logic [31:0] rbytes; logic [2:0] nack_at;
      logic [31:0] exp_rdata; logic exp_err;
   } vec_t;

   cmd_t cmd_q[$];
   fin_t fin_q[$];
   int n_tests = 0, n_fail = 0;
   int done_cnt = 0, abort_cnt = 0, read_hs_cnt = 0, cyc = 0;
   int hs_cyc = 0, abort_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic void push_cmd(input logic [2:0] op, input logic [7:0] data,
                                    input logic mack, input logic nack,
                                    input logic [7:0] rbyte, input logic silent);
      cmd_t c;
      c.op = op; c.data = data; c.mack = mack; c.nack = nack; c.rbyte = rbyte; c.silent = silent;
      cmd_q.push_back(c);
   endfunction

   // Expected command stream and completion record for one transaction.
   function automatic void push_txn(input vec_t v);
      fin_t f;
      push_cmd(OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      push_cmd(OP_WRITE, {v.dev, 1'b0}, 1'b0, v.nack_at == 3'd1, 8'h00, 1'b0);
      if (v.nack_at != 3'd1) begin
         push_cmd(OP_WRITE, v.sub, 1'b0, v.nack_at == 3'd2, 8'h00, 1'b0);
         if (v.nack_at != 3'd2) begin
            if (!v.rw) begin
               push_cmd(OP_WRITE, v.wdata, 1'b0, v.nack_at == 3'd3, 8'h00, 1'b0);
            end else begin
               push_cmd(OP_RSTART, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
               push_cmd(OP_WRITE, {v.dev, 1'b1}, 1'b0, v.nack_at == 3'd4, 8'h00, 1'b0);
               if (v.nack_at != 3'd4)
                  for (int i = 0; i <= int'(v.len); i++)
                     push_cmd(OP_READ, 8'h00, i == int'(v.len), 1'b0, v.rbytes[31-8*i -: 8], 1'b0);
            end
         end
      end
      push_cmd(OP_STOP, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      f.done = v.idx ? 2'b10 : 2'b01; f.err = v.exp_err; f.rdata = v.exp_rdata;
      fin_q.push_back(f);
   endfunction

   task automatic drive(input vec_t v);
      int i;
      i = int'(v.idx);
      req_rw[i] = v.rw;
      req_dev[7*i +: 7] = v.dev;
      req_sub[8*i +: 8] = v.sub;
      req_wdata[8*i +: 8] = v.wdata;
      req_len[2*i +: 2] = v.len;
      req[i] = 1'b1;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      check("done within budget", 32'(done_cnt >= target), 32'd1);
   endtask

   // Byte-engine model and output monitor, all evaluated on the falling edge.
   logic busy = 1'b0;
   logic prev_stall = 1'b0;
   logic [2:0] prev_op = 3'd0;
   logic [7:0] prev_data = 8'h00;
   int dly = 0;
   cmd_t cur;

   initial begin
      fin_t f;
      forever begin
         @(negedge clk);
         rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
         if (done != 2'b00) begin
            done_cnt++;
            if (fin_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected done: got %b, expected none", done);
            end else begin
               f = fin_q.pop_front();
               check("done vector", 32'(done), 32'(f.done));
               check("err", 32'(err), 32'(f.err));
               check("rdata", rdata, f.rdata);
            end
         end
         if (eng_abort === 1'b1) begin
            abort_cnt++; abort_cyc = cyc; busy = 1'b0;
         end
         if (reset) begin
            busy = 1'b0; prev_stall = 1'b0; cmd_ready = 1'b1;
         end else begin
            if (busy && !cur.silent) begin
               if (dly == 0) begin
                  rsp_valid = 1'b1; rsp_nack = cur.nack; rsp_data = cur.rbyte; busy = 1'b0;
               end else dly--;
            end
            cmd_ready = ($urandom_range(0, 3) != 0);
            if (cmd_valid && prev_stall) begin
               check("cmd_op stable", 32'(cmd_op), 32'(prev_op));
               check("cmd_data stable", 32'(cmd_data), 32'(prev_data));
            end
            prev_stall = 1'b0;
            if (cmd_valid && cmd_ready) begin
               if (cmd_q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL unexpected cmd: got op %0d data %h, expected none", cmd_op, cmd_data);
                  cur.op = cmd_op; cur.data = cmd_data; cur.mack = 1'b0;
                  cur.nack = 1'b0; cur.rbyte = 8'h00; cur.silent = 1'b0;
               end else begin
                  cur = cmd_q.pop_front();
                  check("cmd_op", 32'(cmd_op), 32'(cur.op));
                  if (cur.op == OP_WRITE) check("cmd_data", 32'(cmd_data), 32'(cur.data));
                  if (cur.op == OP_READ) begin
                     check("cmd_mack", 32'(cmd_mack), 32'(cur.mack));
                     read_hs_cnt++;
                  end
               end
               busy = 1'b1; dly = $urandom_range(0, 2); hs_cyc = cyc;
            end else if (cmd_valid) begin
               prev_stall = 1'b1; prev_op = cmd_op; prev_data = cmd_data;
            end else if (!busy && !rsp_valid && $urandom_range(0, 3) == 0) begin
               // Stray response while nothing is outstanding: must be ignored.
               rsp_valid = 1'b1; rsp_nack = 1'b1; rsp_data = 8'hFF;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   vec_t vecs[9];
   vec_t va, vb;

   initial begin
      int tgt, sz0, n, a0, d0, rh0, d;
      vecs[0] = '{1'b0, 1'b0, 7'h48, 8'h01, 8'h5A, 2'd0, 32'h0000_0000, 3'd0, 32'h0000_0000, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 7'h48, 8'h00, 8'h00, 2'd1, 32'h1234_0000, 3'd0, 32'h0000_1234, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 7'h21, 8'h7F, 8'h00, 2'd3, 32'hDEAD_BEEF, 3'd0, 32'hDEAD_BEEF, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 7'h7F, 8'hFF, 8'h00, 2'd0, 32'hA500_0000, 3'd0, 32'h0000_00A5, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 7'h48, 8'h10, 8'h33, 2'd0, 32'h0000_0000, 3'd1, 32'h0000_0000, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 7'h50, 8'h20, 8'hC3, 2'd0, 32'h0000_0000, 3'd3, 32'h0000_0000, 1'b1};
      vecs[6] = '{1'b0, 1'b1, 7'h11, 8'h02, 8'h00, 2'd2, 32'h0000_0000, 3'd4, 32'h0000_0000, 1'b1};
      vecs[7] = '{1'b1, 1'b1, 7'h22, 8'h03, 8'h00, 2'd2, 32'h0000_0000, 3'd2, 32'h0000_0000, 1'b1};
      vecs[8] = '{1'b0, 1'b1, 7'h33, 8'h04, 8'h00, 2'd2, 32'h0102_0300, 3'd0, 32'h0001_0203, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("reset cmd_valid", 32'(cmd_valid), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset rdata", rdata, 32'd0);
      check("reset eng_abort", 32'(eng_abort), 32'd0);
      reset = 1'b0;

      // Table-driven single transactions
      for (int i = 0; i < 9; i++) begin
         tgt = done_cnt + 1;
         push_txn(vecs[i]);
         drive(vecs[i]);
         wait_done(tgt, 600);
         req = 2'b00;
         check("cmd queue drained", 32'(cmd_q.size()), 32'd0);
      end

      // Both requesting from reset: 0 then 1, then 0 again on the next pair
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      va = vecs[0];
      vb = vecs[0]; vb.idx = 1'b1; vb.dev = 7'h3C; vb.sub = 8'h55; vb.wdata = 8'hAA;
      for (int r = 0; r < 2; r++) begin
         tgt = done_cnt + 1;
         push_txn(va); push_txn(vb);
         drive(va); drive(vb);
         wait_done(tgt, 600);
         req[0] = 1'b0;
         wait_done(tgt + 1, 600);
         req = 2'b00;
      end

      // Request dropped after the first command: transaction still completes
      vb = vecs[1];
      tgt = done_cnt + 1;
      push_txn(vb);
      sz0 = cmd_q.size();
      drive(vb);
      n = 0;
      while (cmd_q.size() >= sz0 && n < 100) begin @(negedge clk); #1; n++; end
      req = 2'b00;
      wait_done(tgt, 600);

      // Timeout: engine never answers START
      va = vecs[0];
      push_cmd(OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
      fin_q.push_back('{2'b01, 1'b1, 32'h0});
      a0 = abort_cnt;
      tgt = done_cnt + 1;
      drive(va);
      wait_done(tgt, 200);
      req = 2'b00;
      d = abort_cyc - hs_cyc;
      check("timeout latency in range", 32'(d >= int'(TMO) && d <= int'(TMO) + 2), 32'd1);
      repeat (10) @(negedge clk);
      #1;
      check("single abort pulse", 32'(abort_cnt - a0), 32'd1);
      check("no STOP after timeout", 32'(cmd_q.size()), 32'd0);

      // Reset during READ: no done, engine freed, next request starts at START
      vb = vecs[2]; vb.idx = 1'b1;
      push_txn(vb);
      rh0 = read_hs_cnt;
      drive(vb);
      n = 0;
      while (read_hs_cnt < rh0 + 2 && n < 600) begin @(negedge clk); #1; n++; end
      check("reached READ phase", 32'(read_hs_cnt >= rh0 + 2), 32'd1);
      d0 = done_cnt;
      reset = 1'b1;
      @(posedge clk); #1;
      check("cmd_valid low after reset", 32'(cmd_valid), 32'd0);
      req = 2'b00;
      @(negedge clk);
      cmd_q.delete(); fin_q.delete();
      @(negedge clk); #1;
      reset = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      check("no done after reset", 32'(done_cnt - d0), 32'd0);
      check("no cmd after reset", 32'(cmd_valid), 32'd0);
      tgt = done_cnt + 1;
      push_txn(vecs[0]);
      drive(vecs[0]);
      wait_done(tgt, 600);
      req = 2'b00;

      repeat (5) @(negedge clk);
      #1;
      check("final cmd queue empty", 32'(cmd_q.size()), 32'd0);
      check("final done queue empty", 32'(fin_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
